mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator between the core's execute stage and the word-organised data memory. Accepts byte-addressed RISC-V load/store requests and converts them into word-address, byte-enable, lane-shifted memory accesses. Loads read raw 32-bit words and are shifted and extended here. Optionally splits word-crossing misaligned accesses into two memory cycles.

## Interface
- ADDR_WIDTH, 15, memory word-address width (32K words)
- DATA_WIDTH, 32, data width; only 32 is supported
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse (loads and stores)
- resp_err  out  1  valid with resp_valid; illegal funct3 or unsupported misalignment
- resp_rdata  out  32  extended load data; 0 for stores and errors
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_op_read  out  3  constant 3'b010, so memory returns the raw word
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  32  lane-shifted write data
- mem_rdata  in  32  raw word, combinational from mem_addr

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register the request and go to ACC0.
  - If the request is illegal, go to RESP with the error flagged.
  - Illegal: funct3 ∈ {011,110,111}, a store with 100/101, or misalignment without MISALIGNED_EN.
- Access geometry:
  - Size n = 1, 2 or 4 bytes; offset o = addr[1:0]; m = ((1<<n)-1) << o, an 8-bit mask.
  - Misaligned: h with o[0]=1, or w with o≠0.
  - Crossing: o+n > 4.
- ACC0:
  - mem_addr = addr[ADDR_WIDTH+1:2]; mem_be = m[3:0].
  - mem_wdata = wdata << 8·o; mem_we = req_we.
  - On a load, capture mem_rdata as w0.
  - Next state: ACC1 if crossing, else RESP.
- ACC1:
  - mem_addr = first word + 1, wrapping modulo 2^ADDR_WIDTH; mem_be = m[7:4].
  - mem_wdata = wdata >> 8·(4−o); mem_we = req_we.
  - On a load, capture mem_rdata as w1. Next state: RESP.
- RESP:
  - resp_valid=1.
  - Load data = ({w1,w0} >> 8·o) truncated to n bytes, then sign-extended (000/001) or zero-extended (100/101); w1=0 if not crossing.
  - Next state: IDLE.
- mem_we=0 and mem_be=0 in IDLE and RESP.
- Error path: no memory access ever; resp_err=1, resp_rdata=0.

## Timing
- Request accepted on edge T (req_valid & req_ready).
- Aligned or non-crossing access: ACC0 in cycle T+1, resp_valid in T+2.
- Crossing access: ACC0 in T+1, ACC1 in T+2, resp_valid in T+3.
- Error: resp_valid with resp_err in T+1.
- Back-to-back: next request accepted in the RESP→IDLE cycle at the earliest, i.e. one idle cycle between responses. resp_valid has no backpressure.
- Reset values: state IDLE; req_ready=1 after reset.
- Outputs 0 after reset: resp_valid, resp_err, resp_rdata, mem_we, mem_be, mem_addr, mem_wdata.
- rst overrides everything on the same edge.
- Reset mid-operation: abandons the request with no response and no ACC1 write. An ACC0 write already committed remains in memory.
- req_valid while not in IDLE is ignored and not stored.

## Configuration
- MISALIGNED_EN defined:
  - Misaligned h/w loads and stores are legal.
  - Non-crossing ones take one access; crossing ones take two.
- MISALIGNED_EN undefined:
  - ACC1 is unreachable and may be omitted.
  - Every misaligned request returns resp_err=1 in T+1 with no memory write.
  - Aligned behaviour is identical in both builds.

## Test plan
- sw 0xDEADBEEF @0x100, then lw @0x100 → mem_addr=0x40, be=1111; load resp_rdata=0xDEADBEEF at T+2.
- sb 0xA5 @0x102 over word 0x11223344 → be=0100, mem_wdata=0x00A50000; lbu @0x102 → 0xA5; lb → 0xFFFFFFA5.
- (MISALIGNED_EN) sh 0xBEEF @0x103:
  - ACC0: word 0x40, be=1000, wdata[31:24]=0xEF.
  - ACC1: word 0x41, be=0001, wdata[7:0]=0xBE.
  - lh @0x103 → 0xFFFFBEEF at T+3.
- (MISALIGNED_EN) lw @0x1FFFF (last word, o=3) → second access at mem_addr=0 (wrap).
- Without MISALIGNED_EN: lw @0x101 → resp_valid with resp_err=1 at T+1, mem_we never asserted. funct3=011 gives the same result in either build.
- (MISALIGNED_EN) rst asserted during ACC1 of a crossing sw → no ACC1 write, no resp_valid; req_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/mem_access_unit.sv
// Byte-addressed RISC-V load/store initiator driving a word-organised data memory.
// Build option MISALIGNED_EN: legalises misaligned h/w accesses, splitting word-crossing ones in two.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [2:0]            mem_op_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

`ifdef MISALIGNED_EN
  localparam bit MisalignedEn = 1'b1;
`else
  localparam bit MisalignedEn = 1'b0;
`endif

  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic [7:0]            mask_q, mask_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [DW-1:0]         w0_q, w0_d;
  logic [DW-1:0]         w1_q, w1_d;
  logic                  err_q, err_d;

  logic [3:0]            base_mask;
  logic [7:0]            req_mask;
  logic                  misaligned;
  logic                  illegal;
  logic [2*DW-1:0]       wr_shift;
  logic [DW-1:0]         rd_word;
  logic                  sign_ext;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];
  assign mem_op_read      = 3'b010;

  // Request decode, evaluated on the raw inputs while in IDLE.
  always_comb begin
    base_mask = 4'b0000;
    case (req_funct3[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      2'b10:   base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase
    req_mask   = {4'b0000, base_mask} << req_addr[1:0];
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                 (req_we && req_funct3[2]) || (misaligned && !MisalignedEn);
  end

  // Lower half feeds the first word, upper half spills into the next word.
  assign wr_shift = {{DW{1'b0}}, wdata_q} << {off_q, 3'b000};
  assign rd_word  = DW'({w1_q, w0_q} >> {off_q, 3'b000});
  assign sign_ext = !f3_q[2];

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    f3_d       = f3_q;
    off_d      = off_q;
    mask_d     = mask_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_we     = 1'b0;
    mem_be     = 4'b0000;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          off_d   = req_addr[1:0];
          mask_d  = req_mask;
          word_d  = req_addr[ADDR_WIDTH+1:2];
          wdata_d = req_wdata;
          err_d   = illegal;
          w0_d    = '0;
          w1_d    = '0;
          state_d = illegal ? RESP : ACC0;
        end
      end
      ACC0: begin
        mem_addr  = word_q;
        mem_be    = mask_q[3:0];
        mem_wdata = wr_shift[DW-1:0];
        mem_we    = we_q;
        if (!we_q) w0_d = mem_rdata;
        state_d = (|mask_q[7:4]) ? ACC1 : RESP;
      end
      ACC1: begin
        mem_addr  = word_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        mem_be    = mask_q[7:4];
        mem_wdata = wr_shift[2*DW-1:DW];
        mem_we    = we_q;
        if (!we_q) w1_d = mem_rdata;
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && !we_q) begin
          case (f3_q[1:0])
            2'b00:   resp_rdata = {{(DW-8){sign_ext & rd_word[7]}}, rd_word[7:0]};
            2'b01:   resp_rdata = {{(DW-16){sign_ext & rd_word[15]}}, rd_word[15:0]};
            default: resp_rdata = rd_word;
          endcase
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset also squashes the access in flight this cycle, so a pending second write never lands.
    if (rst) begin
      mem_we     = 1'b0;
      mem_be     = 4'b0000;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      mask_q  <= 8'h00;
      word_q  <= '0;
      wdata_q <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      mask_q  <= mask_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected memory accesses and
// responses; an independent monitor compares them as the DUT presents them.
module tb_mem_access_unit;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic          resp_err;
  logic [31:0]   resp_rdata;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [2:0]    mem_op_read;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_we(mem_we), .mem_be(mem_be), .mem_op_read(mem_op_read),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Word memory with combinational read and byte-enabled write.
  logic [31:0] mem [0:(1<<AW)-1];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    string       name;
  } rexp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic          we;
    logic [31:0]   wdata;
    string         name;
  } aexp_t;

  rexp_t rq[$];
  aexp_t aq[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_acc(input string name, input logic [AW-1:0] addr, input logic [3:0] be,
                            input logic we, input logic [31:0] wdata);
    aexp_t e;
    e.addr = addr; e.be = be; e.we = we; e.wdata = wdata; e.name = name;
    aq.push_back(e);
  endtask

  // lat = 0 means the request is expected to be abandoned without a response.
  task automatic issue(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    int waited;
    rexp_t e;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk({name, "_ready_timeout"}, {31'b0, req_ready}, 32'h1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    if (lat > 0) begin
      e.rdata = exp_rdata; e.err = exp_err; e.due = cyc + lat; e.name = name;
      rq.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || aq.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Monitor: memory-side accesses and responses, sampled on the falling edge.
  initial begin
    aexp_t a;
    rexp_t r;
    forever begin
      @(negedge clk);
      if (mem_we || mem_be != 4'b0000) begin
        if (aq.size() == 0) begin
          chk("spurious_access", {27'b0, mem_we, mem_be}, 32'h0);
        end else begin
          a = aq.pop_front();
          $display("[%0d] access %s addr=0x%04h be=%b we=%b wdata=0x%08h",
                   cyc, a.name, mem_addr, mem_be, mem_we, mem_wdata);
          chk({a.name, "_addr"}, {17'b0, mem_addr}, {17'b0, a.addr});
          chk({a.name, "_be"}, {28'b0, mem_be}, {28'b0, a.be});
          chk({a.name, "_we"}, {31'b0, mem_we}, {31'b0, a.we});
          chk({a.name, "_wdata"}, mem_wdata, a.wdata);
        end
      end
      if (resp_valid) begin
        if (rq.size() == 0) begin
          chk("spurious_resp", {31'b0, resp_valid}, 32'h0);
        end else begin
          r = rq.pop_front();
          $display("[%0d] resp %s rdata=0x%08h err=%b", cyc, r.name, resp_rdata, resp_err);
          chk({r.name, "_rdata"}, resp_rdata, r.rdata);
          chk({r.name, "_err"}, {31'b0, resp_err}, {31'b0, r.err});
          chk({r.name, "_cycle"}, cyc, r.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
    chk("rst_mem_addr", {17'b0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("mem_op_read", {29'b0, mem_op_read}, 32'h2);

    // Aligned word store and load.
    expect_acc("sw_deadbeef", 15'h40, 4'b1111, 1'b1, 32'hDEADBEEF);
    issue("sw_deadbeef", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    expect_acc("lw_100", 15'h40, 4'b1111, 1'b0, 32'h0);
    issue("lw_100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Byte store into a known word, then byte/half loads.
    expect_acc("sw_11223344", 15'h40, 4'b1111, 1'b1, 32'h11223344);
    issue("sw_11223344", 1'b1, 3'b010, 32'h100, 32'h11223344, 32'h0, 1'b0, 2);
    expect_acc("sb_a5", 15'h40, 4'b0100, 1'b1, 32'h00A50000);
    issue("sb_a5", 1'b1, 3'b000, 32'h102, 32'h000000A5, 32'h0, 1'b0, 2);
    expect_acc("lbu_102", 15'h40, 4'b0100, 1'b0, 32'h0);
    issue("lbu_102", 1'b0, 3'b100, 32'h102, 32'h0, 32'h000000A5, 1'b0, 2);
    expect_acc("lb_102", 15'h40, 4'b0100, 1'b0, 32'h0);
    issue("lb_102", 1'b0, 3'b000, 32'h102, 32'h0, 32'hFFFFFFA5, 1'b0, 2);
    expect_acc("lhu_102", 15'h40, 4'b1100, 1'b0, 32'h0);
    issue("lhu_102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h000011A5, 1'b0, 2);
    expect_acc("lb_101", 15'h40, 4'b0010, 1'b0, 32'h0);
    issue("lb_101", 1'b0, 3'b000, 32'h101, 32'h0, 32'h00000033, 1'b0, 2);

    // Half store with negative value; lane data is not masked by the unit.
    expect_acc("sh_8001", 15'h40, 4'b0011, 1'b1, 32'hFFFF8001);
    issue("sh_8001", 1'b1, 3'b001, 32'h100, 32'hFFFF8001, 32'h0, 1'b0, 2);
    expect_acc("lh_100", 15'h40, 4'b0011, 1'b0, 32'h0);
    issue("lh_100", 1'b0, 3'b001, 32'h100, 32'h0, 32'hFFFF8001, 1'b0, 2);
    expect_acc("lhu_100", 15'h40, 4'b0011, 1'b0, 32'h0);
    issue("lhu_100", 1'b0, 3'b101, 32'h100, 32'h0, 32'h00008001, 1'b0, 2);

    // Illegal encodings: error in T+1, no memory access.
    issue("ld_f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1);
    issue("st_f3_111", 1'b1, 3'b111, 32'h100, 32'h12345678, 32'h0, 1'b1, 1);
    issue("st_f3_100", 1'b1, 3'b100, 32'h100, 32'h000000FF, 32'h0, 1'b1, 1);
    issue("ld_f3_110", 1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1'b1, 1);

    // A request presented while busy must be ignored.
    expect_acc("lw_busy", 15'h40, 4'b1111, 1'b0, 32'h0);
    issue("lw_busy", 1'b0, 3'b010, 32'h100, 32'h0, 32'h11A58001, 1'b0, 2);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = 32'hCAFEBABE;
    @(posedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;

`ifdef MISALIGNED_EN
    expect_acc("sw_0_104", 15'h41, 4'b1111, 1'b1, 32'h0);
    issue("sw_0_104", 1'b1, 3'b010, 32'h104, 32'h0, 32'h0, 1'b0, 2);
    expect_acc("sh_beef_a0", 15'h40, 4'b1000, 1'b1, 32'hEF000000);
    expect_acc("sh_beef_a1", 15'h41, 4'b0001, 1'b1, 32'h000000BE);
    issue("sh_beef", 1'b1, 3'b001, 32'h103, 32'h0000BEEF, 32'h0, 1'b0, 3);
    expect_acc("lh_103_a0", 15'h40, 4'b1000, 1'b0, 32'h0);
    expect_acc("lh_103_a1", 15'h41, 4'b0001, 1'b0, 32'h0);
    issue("lh_103", 1'b0, 3'b001, 32'h103, 32'h0, 32'hFFFFBEEF, 1'b0, 3);

    expect_acc("sw_last", 15'h7FFF, 4'b1111, 1'b1, 32'h44332211);
    issue("sw_last", 1'b1, 3'b010, 32'h1FFFC, 32'h44332211, 32'h0, 1'b0, 2);
    expect_acc("sw_zero", 15'h0, 4'b1111, 1'b1, 32'h88776655);
    issue("sw_zero", 1'b1, 3'b010, 32'h0, 32'h88776655, 32'h0, 1'b0, 2);
    expect_acc("lh_1fffd", 15'h7FFF, 4'b0110, 1'b0, 32'h0);
    issue("lh_1fffd", 1'b0, 3'b001, 32'h1FFFD, 32'h0, 32'h00003322, 1'b0, 2);
    expect_acc("lw_wrap_a0", 15'h7FFF, 4'b1000, 1'b0, 32'h0);
    expect_acc("lw_wrap_a1", 15'h0, 4'b0111, 1'b0, 32'h0);
    issue("lw_wrap", 1'b0, 3'b010, 32'h1FFFF, 32'h0, 32'h77665544, 1'b0, 3);

    // Reset during ACC1 of a crossing store: first half lands, second half and response do not.
    expect_acc("sw_5a_108", 15'h42, 4'b1111, 1'b1, 32'h5A5A5A5A);
    issue("sw_5a_108", 1'b1, 3'b010, 32'h108, 32'h5A5A5A5A, 32'h0, 1'b0, 2);
    drain();
    expect_acc("sw_rst_a0", 15'h41, 4'b1110, 1'b1, 32'hFEF00D00);
    issue("sw_rst", 1'b1, 3'b010, 32'h105, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_req_ready", {31'b0, req_ready}, 32'h1);
    expect_acc("lw_108", 15'h42, 4'b1111, 1'b0, 32'h0);
    issue("lw_108", 1'b0, 3'b010, 32'h108, 32'h0, 32'h5A5A5A5A, 1'b0, 2);
    expect_acc("lw_104", 15'h41, 4'b1111, 1'b0, 32'h0);
    issue("lw_104", 1'b0, 3'b010, 32'h104, 32'h0, 32'hFEF00DBE, 1'b0, 2);
`else
    // Misaligned requests are errors in this build and never touch memory.
    issue("lw_101_err", 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1'b1, 1);
    issue("sh_103_err", 1'b1, 3'b001, 32'h103, 32'h0000BEEF, 32'h0, 1'b1, 1);
    issue("lh_101_err", 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1'b1, 1);
    issue("sw_102_err", 1'b1, 3'b010, 32'h102, 32'h99999999, 32'h0, 1'b1, 1);
    expect_acc("lw_after_err", 15'h40, 4'b1111, 1'b0, 32'h0);
    issue("lw_after_err", 1'b0, 3'b010, 32'h100, 32'h0, 32'h11A58001, 1'b0, 2);
`endif

    drain();
    repeat (3) @(negedge clk);
    chk("resp_queue_empty", rq.size(), 32'h0);
    chk("access_queue_empty", aq.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
